// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: stage hazard info in, stage stall/flush/forward controls out.
// master drives stage info; slave (pipe_ctrl) returns the controls.
interface pipe_ctrl_if;
  logic [4:0]  rs1_raddr_D;
  logic [4:0]  rs2_raddr_D;
  logic        rs1_used_D;
  logic        rs2_used_D;
  logic [4:0]  rs1_raddr_E;
  logic [4:0]  rs2_raddr_E;
  logic [4:0]  rd_waddr_E;
  logic [4:0]  rd_waddr_M;
  logic [4:0]  rd_waddr_RB;
  logic        rd_wen_E;
  logic        rd_wen_M;
  logic        rd_wen_RB;
  logic [1:0]  PMAItoReg_E;
  logic        branch_taken_E;
  logic        mem_req_M;
  logic        mem_ready;
  logic        stall_F;
  logic        stall_D;
  logic        stall_E;
  logic        stall_M;
  logic        flush_D;
  logic        flush_E;
  logic        bubble_RB;
  logic [1:0]  fwd_rs1_sel_E;
  logic [1:0]  fwd_rs2_sel_E;
  logic        mem_err;
  logic [15:0] stall_cnt;

  modport master (
    output rs1_raddr_D,
    output rs2_raddr_D,
    output rs1_used_D,
    output rs2_used_D,
    output rs1_raddr_E,
    output rs2_raddr_E,
    output rd_waddr_E,
    output rd_waddr_M,
    output rd_waddr_RB,
    output rd_wen_E,
    output rd_wen_M,
    output rd_wen_RB,
    output PMAItoReg_E,
    output branch_taken_E,
    output mem_req_M,
    output mem_ready,
    input  stall_F,
    input  stall_D,
    input  stall_E,
    input  stall_M,
    input  flush_D,
    input  flush_E,
    input  bubble_RB,
    input  fwd_rs1_sel_E,
    input  fwd_rs2_sel_E,
    input  mem_err,
    input  stall_cnt
  );

  modport slave (
    input  rs1_raddr_D,
    input  rs2_raddr_D,
    input  rs1_used_D,
    input  rs2_used_D,
    input  rs1_raddr_E,
    input  rs2_raddr_E,
    input  rd_waddr_E,
    input  rd_waddr_M,
    input  rd_waddr_RB,
    input  rd_wen_E,
    input  rd_wen_M,
    input  rd_wen_RB,
    input  PMAItoReg_E,
    input  branch_taken_E,
    input  mem_req_M,
    input  mem_ready,
    output stall_F,
    output stall_D,
    output stall_E,
    output stall_M,
    output flush_D,
    output flush_E,
    output bubble_RB,
    output fwd_rs1_sel_E,
    output fwd_rs2_sel_E,
    output mem_err,
    output stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard, forwarding and data-memory wait control for the pipe.
// Define PIPE_CTRL_FORWARD_EN to forward M/RB results into E.
module pipe_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter logic [1:0]  LOAD_SEL    = 2'b01
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave p
);

  typedef enum logic {
    RUN,
    MEMWAIT
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state_q;
  state_t      state_d;
  logic [7:0]  wait_q;
  logic [7:0]  wait_d;
  logic        err_q;
  logic        err_d;
  logic [15:0] cnt_q;

  logic        mem_hold;
  logic        d_hit_e;
  logic        lu_haz;
  logic        data_haz;
  logic        stall_f;
  logic        stall_d;
  logic        stall_e;
  logic        stall_m;
  logic        flush_d;
  logic        flush_e;
  logic        bubble_rb;
  logic [1:0]  fwd1;
  logic [1:0]  fwd2;

  function automatic logic hit(
    input logic       used,
    input logic [4:0] src,
    input logic       wen,
    input logic [4:0] dst
  );
    return used && wen && (dst != 5'd0) && (src == dst);
  endfunction

  assign d_hit_e =
    hit(p.rs1_used_D, p.rs1_raddr_D, p.rd_wen_E, p.rd_waddr_E) ||
    hit(p.rs2_used_D, p.rs2_raddr_D, p.rd_wen_E, p.rd_waddr_E);

  assign lu_haz = (p.PMAItoReg_E == LOAD_SEL) && d_hit_e;

`ifdef PIPE_CTRL_FORWARD_EN
  assign data_haz = lu_haz;

  // M is younger than RB, so its result wins
  always_comb begin
    fwd1 = 2'b00;
    fwd2 = 2'b00;
    if (hit(1'b1, p.rs1_raddr_E, p.rd_wen_M, p.rd_waddr_M))
      fwd1 = 2'b01;
    else if (hit(1'b1, p.rs1_raddr_E, p.rd_wen_RB, p.rd_waddr_RB))
      fwd1 = 2'b10;
    if (hit(1'b1, p.rs2_raddr_E, p.rd_wen_M, p.rd_waddr_M))
      fwd2 = 2'b01;
    else if (hit(1'b1, p.rs2_raddr_E, p.rd_wen_RB, p.rd_waddr_RB))
      fwd2 = 2'b10;
  end
`else
  logic d_hit_m;
  logic unused_fwd;

  assign d_hit_m =
    hit(p.rs1_used_D, p.rs1_raddr_D, p.rd_wen_M, p.rd_waddr_M) ||
    hit(p.rs2_used_D, p.rs2_raddr_D, p.rd_wen_M, p.rd_waddr_M);

  // regfile is write-first, so an RB producer never needs a stall
  assign data_haz = d_hit_e || d_hit_m;
  assign fwd1 = 2'b00;
  assign fwd2 = 2'b00;
  assign unused_fwd = ^{p.rs1_raddr_E, p.rs2_raddr_E,
                        p.rd_waddr_RB, p.rd_wen_RB, lu_haz};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      wait_q  <= 8'd0;
      err_q   <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      if (stall_d && (cnt_q != 16'hFFFF))
        cnt_q <= cnt_q + 16'd1;
    end
  end

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    err_d    = err_q;
    mem_hold = 1'b0;
    unique case (state_q)
      RUN: begin
        if (p.mem_req_M && !p.mem_ready) begin
          mem_hold = 1'b1;
          wait_d   = 8'd0;
          state_d  = MEMWAIT;
        end
      end
      MEMWAIT: begin
        if (p.mem_ready) begin
          state_d = RUN;
        end else begin
          mem_hold = 1'b1;
          wait_d   = wait_q + 8'd1;
          // counter reaches MEM_TIMEOUT on this edge
          if (wait_q == WAIT_LAST) begin
            err_d   = 1'b1;
            state_d = RUN;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    stall_e   = 1'b0;
    stall_m   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    bubble_rb = 1'b0;
    if (!rst) begin
      if (mem_hold) begin
        stall_f   = 1'b1;
        stall_d   = 1'b1;
        stall_e   = 1'b1;
        stall_m   = 1'b1;
        bubble_rb = 1'b1;
      end else if (p.branch_taken_E) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (data_haz) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  assign p.stall_F       = stall_f;
  assign p.stall_D       = stall_d;
  assign p.stall_E       = stall_e;
  assign p.stall_M       = stall_m;
  assign p.flush_D       = flush_d;
  assign p.flush_E       = flush_e;
  assign p.bubble_RB     = bubble_rb;
  assign p.fwd_rs1_sel_E = rst ? 2'b00 : fwd1;
  assign p.fwd_rs2_sel_E = rst ? 2'b00 : fwd2;
  assign p.mem_err       = err_q;
  assign p.stall_cnt     = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed checks of pipe_ctrl hazards, memory wait and reset.
// Expectations follow PIPE_CTRL_FORWARD_EN when it is defined.
module tb_pipe_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  pipe_ctrl_if bus();

  pipe_ctrl #(
    .MEM_TIMEOUT(4),
    .LOAD_SEL   (2'b01)
  ) dut (
    .clk(clk),
    .rst(rst),
    .p  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] ctl;
  logic [3:0] fwd;
  assign ctl = {bus.stall_F, bus.stall_D, bus.stall_E, bus.stall_M,
                bus.flush_D, bus.flush_E, bus.bubble_RB};
  assign fwd = {bus.fwd_rs1_sel_E, bus.fwd_rs2_sel_E};

  localparam logic [6:0] IDLE = 7'b0000000;
  localparam logic [6:0] HOLD = 7'b1111001;
  localparam logic [6:0] LU   = 7'b1100010;
  localparam logic [6:0] BR   = 7'b0000110;

`ifdef PIPE_CTRL_FORWARD_EN
  localparam int         LU_CNT  = 1;
  localparam logic [6:0] LU_C2   = IDLE;
  localparam logic [6:0] CFG_HAZ = IDLE;
  localparam logic [3:0] F_RB    = 4'b1000;
  localparam logic [3:0] F_M     = 4'b0100;
  localparam logic [3:0] F_RS2M  = 4'b0001;
`else
  localparam int         LU_CNT  = 2;
  localparam logic [6:0] LU_C2   = LU;
  localparam logic [6:0] CFG_HAZ = LU;
  localparam logic [3:0] F_RB    = 4'b0000;
  localparam logic [3:0] F_M     = 4'b0000;
  localparam logic [3:0] F_RS2M  = 4'b0000;
`endif

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.rs1_raddr_D    = 5'd0;
    bus.rs2_raddr_D    = 5'd0;
    bus.rs1_used_D     = 1'b0;
    bus.rs2_used_D     = 1'b0;
    bus.rs1_raddr_E    = 5'd0;
    bus.rs2_raddr_E    = 5'd0;
    bus.rd_waddr_E     = 5'd0;
    bus.rd_waddr_M     = 5'd0;
    bus.rd_waddr_RB    = 5'd0;
    bus.rd_wen_E       = 1'b0;
    bus.rd_wen_M       = 1'b0;
    bus.rd_wen_RB      = 1'b0;
    bus.PMAItoReg_E    = 2'b00;
    bus.branch_taken_E = 1'b0;
    bus.mem_req_M      = 1'b0;
    bus.mem_ready      = 1'b0;
  endtask

  task automatic test_reset;
    idle();
    rst = 1'b1;
    bus.mem_req_M      = 1'b1;
    bus.branch_taken_E = 1'b1;
    bus.rs1_raddr_E    = 5'd3;
    bus.rd_waddr_M     = 5'd3;
    bus.rd_wen_M       = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (ctl !== IDLE) begin
      n_err++;
      $display("FAIL reset_ctl got %b exp %b", ctl, IDLE);
    end
    n_cmp++;
    if (fwd !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_fwd got %b exp %b", fwd, 4'b0000);
    end
    n_cmp++;
    if (bus.mem_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_err got %b exp 0", bus.mem_err);
    end
    n_cmp++;
    if (bus.stall_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL reset_cnt got %0d exp 0", bus.stall_cnt);
    end
    idle();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== IDLE) begin
      n_err++;
      $display("FAIL post_reset_ctl got %b exp %b", ctl, IDLE);
    end
  endtask

  task automatic test_load_use;
    idle();
    bus.rd_waddr_E  = 5'd5;
    bus.rd_wen_E    = 1'b1;
    bus.PMAItoReg_E = 2'b01;
    bus.rs1_raddr_D = 5'd5;
    bus.rs1_used_D  = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== LU) begin
      n_err++;
      $display("FAIL lu_c1 got %b exp %b", ctl, LU);
    end
    tick();
    bus.rd_wen_E    = 1'b0;
    bus.PMAItoReg_E = 2'b00;
    bus.rd_waddr_M  = 5'd5;
    bus.rd_wen_M    = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== LU_C2) begin
      n_err++;
      $display("FAIL lu_c2 got %b exp %b", ctl, LU_C2);
    end
    tick();
    idle();
    bus.rs1_raddr_E = 5'd5;
    bus.rd_waddr_RB = 5'd5;
    bus.rd_wen_RB   = 1'b1;
    #1;
    n_cmp++;
    if (fwd !== F_RB) begin
      n_err++;
      $display("FAIL lu_fwd_rb got %b exp %b", fwd, F_RB);
    end
    n_cmp++;
    if (ctl !== IDLE) begin
      n_err++;
      $display("FAIL lu_c3 got %b exp %b", ctl, IDLE);
    end
    bus.rd_waddr_M = 5'd5;
    bus.rd_wen_M   = 1'b1;
    #1;
    n_cmp++;
    if (fwd !== F_M) begin
      n_err++;
      $display("FAIL lu_fwd_m_first got %b exp %b", fwd, F_M);
    end
    tick();
    n_cmp++;
    if (bus.stall_cnt !== 16'(LU_CNT)) begin
      n_err++;
      $display("FAIL lu_cnt got %0d exp %0d", bus.stall_cnt, LU_CNT);
    end
    idle();
  endtask

  task automatic test_mem_wait;
    idle();
    bus.mem_req_M      = 1'b1;
    bus.branch_taken_E = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (ctl !== HOLD) begin
        n_err++;
        $display("FAIL mw_hold[%0d] got %b exp %b", i, ctl, HOLD);
      end
      tick();
    end
    bus.mem_ready = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== BR) begin
      n_err++;
      $display("FAIL mw_release got %b exp %b", ctl, BR);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (bus.stall_cnt !== 16'(LU_CNT + 3)) begin
      n_err++;
      $display("FAIL mw_cnt got %0d exp %0d", bus.stall_cnt, LU_CNT + 3);
    end
    n_cmp++;
    if (ctl !== IDLE) begin
      n_err++;
      $display("FAIL mw_after got %b exp %b", ctl, IDLE);
    end
  endtask

  task automatic test_timeout;
    idle();
    bus.mem_req_M = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== HOLD) begin
      n_err++;
      $display("FAIL to_enter got %b exp %b", ctl, HOLD);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({ctl, bus.mem_err} !== {HOLD, 1'b0}) begin
        n_err++;
        $display("FAIL to_wait[%0d] got %b/%b exp %b/0",
                 i, ctl, bus.mem_err, HOLD);
      end
      if (i == 3) bus.mem_req_M = 1'b0;
      tick();
    end
    n_cmp++;
    if (bus.mem_err !== 1'b1) begin
      n_err++;
      $display("FAIL to_err got %b exp 1", bus.mem_err);
    end
    n_cmp++;
    if (ctl !== IDLE) begin
      n_err++;
      $display("FAIL to_release got %b exp %b", ctl, IDLE);
    end
    tick();
    tick();
    n_cmp++;
    if (bus.mem_err !== 1'b1) begin
      n_err++;
      $display("FAIL to_sticky got %b exp 1", bus.mem_err);
    end
    n_cmp++;
    if (bus.stall_cnt !== 16'(LU_CNT + 8)) begin
      n_err++;
      $display("FAIL to_cnt got %0d exp %0d", bus.stall_cnt, LU_CNT + 8);
    end
  endtask

  task automatic test_branch_lu;
    idle();
    bus.rd_waddr_E     = 5'd7;
    bus.rd_wen_E       = 1'b1;
    bus.PMAItoReg_E    = 2'b01;
    bus.rs2_raddr_D    = 5'd7;
    bus.rs2_used_D     = 1'b1;
    bus.branch_taken_E = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== BR) begin
      n_err++;
      $display("FAIL br_lu got %b exp %b", ctl, BR);
    end
    tick();
    idle();
  endtask

  task automatic test_x0;
    idle();
    bus.rd_waddr_M  = 5'd0;
    bus.rd_wen_M    = 1'b1;
    bus.rd_waddr_RB = 5'd0;
    bus.rd_wen_RB   = 1'b1;
    bus.rd_waddr_E  = 5'd0;
    bus.rd_wen_E    = 1'b1;
    bus.PMAItoReg_E = 2'b01;
    bus.rs1_used_D  = 1'b1;
    bus.rs2_used_D  = 1'b1;
    #1;
    n_cmp++;
    if ({ctl, fwd} !== {IDLE, 4'b0000}) begin
      n_err++;
      $display("FAIL x0 got %b/%b exp %b/0000", ctl, fwd, IDLE);
    end
    idle();
    bus.rd_waddr_E  = 5'd5;
    bus.PMAItoReg_E = 2'b01;
    bus.rs1_raddr_D = 5'd5;
    bus.rs1_used_D  = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== IDLE) begin
      n_err++;
      $display("FAIL no_wen got %b exp %b", ctl, IDLE);
    end
    bus.rd_wen_E   = 1'b1;
    bus.rs1_used_D = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== IDLE) begin
      n_err++;
      $display("FAIL not_used got %b exp %b", ctl, IDLE);
    end
    idle();
  endtask

  task automatic test_config;
    idle();
    bus.rs1_raddr_D = 5'd9;
    bus.rs1_used_D  = 1'b1;
    bus.rd_waddr_M  = 5'd9;
    bus.rd_wen_M    = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== CFG_HAZ) begin
      n_err++;
      $display("FAIL cfg_m got %b exp %b", ctl, CFG_HAZ);
    end
    bus.rd_wen_M   = 1'b0;
    bus.rd_waddr_E = 5'd9;
    bus.rd_wen_E   = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== CFG_HAZ) begin
      n_err++;
      $display("FAIL cfg_e_alu got %b exp %b", ctl, CFG_HAZ);
    end
    bus.rd_wen_E    = 1'b0;
    bus.rd_waddr_RB = 5'd9;
    bus.rd_wen_RB   = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== IDLE) begin
      n_err++;
      $display("FAIL cfg_rb got %b exp %b", ctl, IDLE);
    end
    idle();
    bus.rs2_raddr_E = 5'd6;
    bus.rd_waddr_M  = 5'd6;
    bus.rd_wen_M    = 1'b1;
    #1;
    n_cmp++;
    if (fwd !== F_RS2M) begin
      n_err++;
      $display("FAIL cfg_fwd_rs2 got %b exp %b", fwd, F_RS2M);
    end
    idle();
  endtask

  task automatic test_rst_memwait;
    idle();
    #1;
    n_cmp++;
    if (bus.mem_err !== 1'b1) begin
      n_err++;
      $display("FAIL rmw_err_held got %b exp 1", bus.mem_err);
    end
    bus.mem_req_M = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    bus.rs1_raddr_E = 5'd5;
    bus.rd_waddr_RB = 5'd5;
    bus.rd_wen_RB   = 1'b1;
    #1;
    n_cmp++;
    if ({ctl, fwd} !== {IDLE, 4'b0000}) begin
      n_err++;
      $display("FAIL rmw_in_rst got %b/%b exp %b/0000", ctl, fwd, IDLE);
    end
    tick();
    n_cmp++;
    if ({bus.mem_err, bus.stall_cnt} !== 17'd0) begin
      n_err++;
      $display("FAIL rmw_regs got err %b cnt %0d exp 0/0",
               bus.mem_err, bus.stall_cnt);
    end
    idle();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== IDLE) begin
      n_err++;
      $display("FAIL rmw_state got %b exp %b", ctl, IDLE);
    end
    tick();
    n_cmp++;
    if ({bus.mem_err, bus.stall_cnt} !== 17'd0) begin
      n_err++;
      $display("FAIL rmw_after got err %b cnt %0d exp 0/0",
               bus.mem_err, bus.stall_cnt);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    idle();
    test_reset();
    test_load_use();
    test_mem_wait();
    test_timeout();
    test_branch_lu();
    test_x0();
    test_config();
    test_rst_memwait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255: max cycles in MEMWAIT before error; legal range 1..255.
REQ-002 Parameter LOAD_SEL, default 2'b01: PMAItoReg encoding meaning "write back memory data" (load).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 rs1_raddr_D, rs2_raddr_D  in  5 each  source registers of the instruction in D.
REQ-006 rs1_used_D, rs2_used_D  in  1 each  the instruction in D reads that source.
REQ-007 rs1_raddr_E, rs2_raddr_E  in  5 each  source registers of the instruction in E.
REQ-008 rd_waddr_E/M/RB  in  5 each, rd_wen_E/M/RB  in  1 each  destinations and write enables of E, M, RB.
REQ-009 PMAItoReg_E  in  2  writeback source select of the instruction in E.
REQ-010 branch_taken_E  in  1  redirect resolved in E.
REQ-011 mem_req_M  in  1, mem_ready  in  1  data-memory access in M and its completion.
REQ-012 stall_F, stall_D, stall_E, stall_M  out  1 each  hold the named stage register.
REQ-013 flush_D, flush_E  out  1 each  load a bubble (rd_wen=0) into the named stage register.
REQ-014 bubble_RB  out  1  force rd_wen_RB to 0 on the next edge.
REQ-015 fwd_rs1_sel_E, fwd_rs2_sel_E  out  2 each  00 regfile, 01 M result, 10 RB result.
REQ-016 mem_err  out  1  sticky memory-timeout flag.
REQ-017 stall_cnt  out  16  saturating count of cycles with stall_D=1.

Function
REQ-018 A hazard match SHALL require the source to be used, producer rd_wen=1, rd_waddr!=0, and equal addresses.
REQ-019 The FSM SHALL have states RUN and MEMWAIT; stall/flush/fwd outputs SHALL be combinational from the state and current inputs.
REQ-020 In RUN, mem_req_M=1 with mem_ready=0 SHALL assert stall_F/D/E/M and bubble_RB in the same cycle and enter MEMWAIT.
REQ-021 In MEMWAIT, all four stalls and bubble_RB SHALL stay 1 until mem_ready=1; in that cycle they drop and the next state is RUN.
REQ-022 An 8-bit wait counter SHALL clear on entering MEMWAIT and increment each MEMWAIT cycle.
REQ-023 When the counter reaches MEM_TIMEOUT, mem_err SHALL set, the stalls SHALL release, and the next state SHALL be RUN.
REQ-024 mem_err SHALL remain set until rst.
REQ-025 Load-use: PMAItoReg_E==LOAD_SEL matching a D source SHALL assert stall_F, stall_D, flush_E for exactly one cycle.
REQ-026 branch_taken_E=1 SHALL assert flush_D and flush_E for one cycle.
REQ-027 Priority SHALL be memory wait > branch > load-use; during a memory wait no flush SHALL assert, and a held branch takes effect on release.
REQ-028 A branch coinciding with a load-use hazard SHALL flush only, with no stall.
REQ-029 stall_cnt SHALL increment each cycle stall_D=1 and saturate at 16'hFFFF.

Reset
REQ-030 While rst=1 on an edge: state=RUN, wait counter=0, mem_err=0, stall_cnt=0.
REQ-031 During rst all stall/flush/bubble outputs SHALL be 0, and fwd selects SHALL be 00.
REQ-032 rst asserted in MEMWAIT SHALL abandon the wait without setting mem_err.

Configuration
REQ-033 Macro PIPE_CTRL_FORWARD_EN defined: fwd selects follow REQ-018 matches for the E sources, M before RB, else 00; only load-use stalls D.
REQ-034 Macro undefined: fwd selects SHALL be tied to 00, and stall_F/D plus flush_E SHALL assert while any D source matches E or M; the regfile is write-first, so RB needs no stall.

Verification
REQ-035 Directed bench scenarios:
- Load x5 in E (PMAItoReg_E=01), D reads x5 -> stall_F=stall_D=flush_E=1 one cycle; next cycle fwd_rs1_sel_E=10 (FORWARD_EN).
- mem_req_M=1, mem_ready low 3 cycles -> stalls+bubble_RB high 3 cycles, low on 4th, stall_cnt=4.
- MEM_TIMEOUT=4, mem_ready never -> mem_err=1 after 4 MEMWAIT cycles, stalls released, mem_err held until rst.
- branch_taken_E=1 with load-use hazard present -> flush_D=flush_E=1, stall_D=0.
- rd x0 producer in M, E reads x0 -> fwd selects 00, no stall; rst mid-MEMWAIT -> all outputs 0 next cycle.
